// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Round-robin arbiter for the shared OR-combined system bus. One level request
//   per master, one-hot registered grant held for a whole transaction (begin to
//   end), with forced release on grant timeout (silent) or transaction timeout
//   (one-cycle bus_error_o pulse).
//
// Ports
//   clk                     system clock, rising edge
//   rst_n                   asynchronous active-low reset
//   arb_request_i           per-master request, level
//   arb_grant_o             one-hot grant, registered
//   bus_beginTransaction_i  combined bus beginTransaction
//   bus_endTransaction_i    combined bus endTransaction
//   bus_busy_i              combined bus busy; blocks new arbitration
//   bus_error_o             one-cycle pulse on transaction timeout
//   arb_owner_o             index of current/last grantee
//   arb_active_o            high while any grant is asserted
//
// State | meaning
//   IDLE  | no grant; arbitrate when a request is present and bus not busy
//   GRANT | grant issued, waiting for beginTransaction (grant timeout)
//   OWNED | transaction in progress, waiting for endTransaction (txn timeout)
module bus_rr_arbiter #(
    parameter  int N_MASTERS     = 4,
    parameter  int GRANT_TIMEOUT = 16,
    parameter  int TXN_TIMEOUT   = 1024,
    localparam int OWNER_W       = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] arb_request_i,
    output logic [N_MASTERS-1:0] arb_grant_o,
    input  logic                 bus_beginTransaction_i,
    input  logic                 bus_endTransaction_i,
    input  logic                 bus_busy_i,
    output logic                 bus_error_o,
    output logic [OWNER_W-1:0]   arb_owner_o,
    output logic                 arb_active_o
);

    localparam int MAX_T = (GRANT_TIMEOUT > TXN_TIMEOUT) ? GRANT_TIMEOUT : TXN_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        OWNED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   active_q, active_d;
    logic                   error_q, error_d;

    logic [2*N_MASTERS-1:0] req2;
    logic [N_MASTERS-1:0]   rot;
    logic [OWNER_W-1:0]     offset;
    logic [OWNER_W:0]       sum;
    logic [OWNER_W-1:0]     winner;
    logic [OWNER_W-1:0]     next_ptr;
    logic                   rel;

    // Rotate requests so bit 0 is the master at ptr; the lowest set bit of the
    // rotated vector is then the round-robin winner's distance from ptr.
    always_comb begin
        req2   = {arb_request_i, arb_request_i};
        rot    = N_MASTERS'(req2 >> ptr_q);
        offset = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) offset = OWNER_W'(i);
        end
        sum = {1'b0, ptr_q} + {1'b0, offset};
        if (sum >= (OWNER_W+1)'(N_MASTERS)) sum = sum - (OWNER_W+1)'(N_MASTERS);
        winner   = sum[OWNER_W-1:0];
        next_ptr = (owner_q == OWNER_W'(N_MASTERS - 1)) ? '0 : owner_q + OWNER_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        active_d = active_q;
        error_d  = 1'b0;
        rel      = 1'b0;
        // saturating count, never wraps
        cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if ((|arb_request_i) && !bus_busy_i) begin
                    state_d  = GRANT;
                    grant_d  = N_MASTERS'(1) << winner;
                    owner_d  = winner;
                    active_d = 1'b1;
                end
            end
            GRANT: begin
                if (bus_beginTransaction_i) begin
                    if (bus_endTransaction_i) begin
                        rel = 1'b1;
                    end else begin
                        state_d = OWNED;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    rel = 1'b1;
                end
            end
            OWNED: begin
                if (bus_endTransaction_i) begin
                    rel = 1'b1;
                end else if (cnt_q == CNT_W'(TXN_TIMEOUT - 1)) begin
                    rel     = 1'b1;
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rel) begin
            state_d  = IDLE;
            grant_d  = '0;
            active_d = 1'b0;
            cnt_d    = '0;
            ptr_d    = next_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            error_q  <= error_d;
        end
    end

    assign arb_grant_o  = grant_q;
    assign arb_owner_o  = owner_q;
    assign arb_active_o = active_q;
    assign bus_error_o  = error_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter
//   Self-checking bench for bus_rr_arbiter (4 masters, default timeouts).
//   Expected grant rises and error pulses are queued when stimulus is driven
//   and compared by a negedge monitor when the DUT produces them.
module tb_bus_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] arb_request_i = '0;
    logic [3:0] arb_grant_o;
    logic       bus_beginTransaction_i = 1'b0;
    logic       bus_endTransaction_i = 1'b0;
    logic       bus_busy_i = 1'b0;
    logic       bus_error_o;
    logic [1:0] arb_owner_o;
    logic       arb_active_o;

    bus_rr_arbiter #(
        .N_MASTERS    (4),
        .GRANT_TIMEOUT(16),
        .TXN_TIMEOUT  (1024)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .arb_request_i         (arb_request_i),
        .arb_grant_o           (arb_grant_o),
        .bus_beginTransaction_i(bus_beginTransaction_i),
        .bus_endTransaction_i  (bus_endTransaction_i),
        .bus_busy_i            (bus_busy_i),
        .bus_error_o           (bus_error_o),
        .arb_owner_o           (arb_owner_o),
        .arb_active_o          (arb_active_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        logic [3:0] grant;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   ptr_m = 0;

    // reference round-robin pick: scan from pointer, wrapping
    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return 0;
    endfunction

    logic [3:0] prev_grant = '0;
    logic       prev_err   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (arb_grant_o != 4'b0 && prev_grant == 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("spur_grant", int'(arb_grant_o), 0);
            end else begin
                e = exp_q.pop_front();
                chk("grant", int'(arb_grant_o), int'(e.grant));
                chk("grant_cyc", cyc, e.cyc);
            end
        end
        chk("onehot", int'($countones(arb_grant_o) <= 1), 1);
        chk("active", int'(arb_active_o), int'(|arb_grant_o));
        if (bus_error_o) begin
            if (err_q.size() == 0) chk("spur_err", int'(bus_error_o), 0);
            else                   chk("err_cyc", cyc, err_q.pop_front());
            chk("err_gnt", int'(arb_grant_o), 0);
        end
        if (bus_error_o && prev_err) chk("err_width", int'(bus_error_o), 0);
        prev_grant = arb_grant_o;
        prev_err   = bus_error_o;
    end

    // Drive a request pattern at a negedge (IDLE cycle), queue the expected
    // winner for the next cycle and wait for the grant to appear.
    task automatic arb(input logic [3:0] r, output int w);
        exp_t e;
        int   n;
        arb_request_i = r;
        w       = pick(r, ptr_m);
        e.grant = 4'(1 << w);
        e.cyc   = cyc + 1;
        exp_q.push_back(e);
        n = 0;
        while (arb_grant_o == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("grant_wait", int'(arb_grant_o), int'(e.grant));
        chk("owner", int'(arb_owner_o), w);
    endtask

    // Called at the negedge where the grant was first seen.
    task automatic txn(input int d_begin, input int d_end, input int w);
        repeat (d_begin) @(negedge clk);
        chk("hold_b", int'(arb_grant_o), 1 << w);
        bus_beginTransaction_i = 1'b1;
        if (d_end == 0) bus_endTransaction_i = 1'b1;
        @(negedge clk);
        bus_beginTransaction_i = 1'b0;
        bus_endTransaction_i   = 1'b0;
        if (d_end > 0) begin
            repeat (d_end - 1) @(negedge clk);
            chk("hold_e", int'(arb_grant_o), 1 << w);
            bus_endTransaction_i = 1'b1;
            @(negedge clk);
            bus_endTransaction_i = 1'b0;
        end
        chk("rel", int'(arb_grant_o), 0);
        chk("rel_act", int'(arb_active_o), 0);
        chk("rel_owner", int'(arb_owner_o), w);
        ptr_m = (w + 1) % 4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arb_request_i = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    initial begin
        int w;
        int g;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", int'(arb_grant_o), 0);
        chk("rst_active", int'(arb_active_o), 0);
        chk("rst_error", int'(bus_error_o), 0);
        chk("rst_owner", int'(arb_owner_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single master: grant next cycle, begin +2, end +3 after that
        arb(4'b0001, w);
        arb_request_i = '0;
        txn(2, 3, w);
        // pointer now 1: master 1 wins over master 0
        arb(4'b0011, w);
        arb_request_i = '0;
        txn(0, 1, w);

        // fairness with all requests held, 4-cycle transactions
        do_reset();
        for (int k = 0; k < 5; k++) begin
            arb(4'b1111, w);
            chk("fair_order", w, k % 4);
            txn(1, 2, w);
        end
        arb_request_i = '0;

        // grant timeout: master 2 never begins, master 3 waiting
        arb(4'b1100, w);
        chk("gto_winner", w, 2);
        arb_request_i = 4'b1000;
        repeat (15) @(negedge clk);
        chk("gto_hold", int'(arb_grant_o), 4'b0100);
        @(negedge clk);
        chk("gto_rel", int'(arb_grant_o), 0);
        ptr_m = 3;
        arb(4'b1000, w);
        chk("gto_next", w, 3);
        arb_request_i = '0;
        txn(0, 0, w);

        // transaction timeout
        arb(4'b0001, w);
        arb_request_i = '0;
        g = cyc;
        bus_beginTransaction_i = 1'b1;
        err_q.push_back(g + 1025);
        @(negedge clk);
        bus_beginTransaction_i = 1'b0;
        repeat (1023) @(negedge clk);
        chk("tto_hold", int'(arb_grant_o), 4'b0001);
        @(negedge clk);
        chk("tto_rel", int'(arb_grant_o), 0);
        chk("tto_err", int'(bus_error_o), 1);
        @(negedge clk);
        chk("tto_err_clr", int'(bus_error_o), 0);
        ptr_m = 1;
        arb(4'b0010, w);
        arb_request_i = '0;
        txn(1, 1, w);

        // busy holds off arbitration; single-beat release
        bus_busy_i    = 1'b1;
        arb_request_i = 4'b0001;
        repeat (4) @(negedge clk);
        chk("busy_nogrant", int'(arb_grant_o), 0);
        bus_busy_i = 1'b0;
        arb(4'b0001, w);
        arb_request_i = '0;
        txn(0, 0, w);

        // asynchronous reset while OWNED
        arb(4'b0010, w);
        arb_request_i = '0;
        bus_beginTransaction_i = 1'b1;
        @(negedge clk);
        bus_beginTransaction_i = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        chk("ar_pre_grant", int'(arb_grant_o), 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("ar_grant", int'(arb_grant_o), 0);
        chk("ar_active", int'(arb_active_o), 0);
        chk("ar_error", int'(bus_error_o), 0);
        chk("ar_owner", int'(arb_owner_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        arb(4'b0100, w);
        arb_request_i = '0;
        txn(1, 1, w);
        // pointer 3 after that: master 3 beats master 0
        arb(4'b1001, w);
        chk("wrap_winner", w, 3);
        arb_request_i = '0;
        txn(0, 1, w);

        repeat (3) @(negedge clk);
        chk("sb_grant_left", exp_q.size(), 0);
        chk("sb_err_left", err_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
